// File: rtl/hazard_pkg.sv
// Shared types and constants for the DEC-stage hazard scoreboard.
package hazard_pkg;

  localparam int REG_W = 5;
  localparam int NREGS = 32;

  typedef enum logic [2:0] {
    SRC_RF,
    SRC_EXE,
    SRC_MEM,
    SRC_WRB,
    SRC_LNG
  } fwd_src_t;

  // One-hot decode of a register address.
  function automatic logic [NREGS-1:0] reg_onehot(input logic [REG_W-1:0] r);
    logic [NREGS-1:0] m;
    m    = '0;
    m[r] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/operand_bypass.sv
// Per-operand bypass mux and hazard detection for one DEC source operand.
module operand_bypass
  import hazard_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [REG_W-1:0] rs,
  input  logic             renb,
  input  logic [XLEN-1:0]  rdata,
  input  logic [REG_W-1:0] exe_rd,
  input  logic             exe_rd_wenb,
  input  logic [XLEN-1:0]  exe_result,
  input  logic             exe_load,
  input  logic             exe_csr,
  input  logic [REG_W-1:0] mem_rd,
  input  logic             mem_rd_wenb,
  input  logic [XLEN-1:0]  mem_result,
  input  logic [REG_W-1:0] wrb_rd,
  input  logic             wrb_rd_wenb,
  input  logic [XLEN-1:0]  wrb_result,
  input  logic             lng_wenb,
  input  logic [REG_W-1:0] lng_rd,
  input  logic [XLEN-1:0]  lng_result,
  input  logic [NREGS-1:0] pending_eff,
  output fwd_src_t         src,
  output logic [XLEN-1:0]  data,
  output logic             raw_exe_stall,
  output logic             raw_lng_stall
);

  logic used;
  logic exe_hit, mem_hit, wrb_hit, lng_hit;

  // x0 is hardwired, so an unused operand and rs==0 both take the RF value.
  assign used    = renb && (rs != '0);
  assign exe_hit = used && exe_rd_wenb && (exe_rd == rs);
  assign mem_hit = used && mem_rd_wenb && (mem_rd == rs);
  assign wrb_hit = used && wrb_rd_wenb && (wrb_rd == rs);
  assign lng_hit = used && lng_wenb && (lng_rd == rs);

  // Youngest producer wins; an EXE load/CSR hit stalls without falling back to older stages.
  always_comb begin
    src           = SRC_RF;
    data          = rdata;
    raw_exe_stall = 1'b0;
    raw_lng_stall = 1'b0;
    if (exe_hit) begin
      src           = SRC_EXE;
      data          = exe_result;
      raw_exe_stall = exe_load || exe_csr;
    end else if (mem_hit) begin
      src  = SRC_MEM;
      data = mem_result;
    end else if (wrb_hit) begin
      src  = SRC_WRB;
      data = wrb_result;
    end else if (lng_hit) begin
      src  = SRC_LNG;
      data = lng_result;
    end
    if (used && pending_eff[rs] && !exe_hit && !mem_hit && !wrb_hit)
      raw_lng_stall = 1'b1;
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// DEC-stage bypass network plus scoreboard of in-flight long-latency writes.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int NSRC     = 2,
  parameter int MAX_LONG = 4,
  parameter int CNT_W    = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NSRC*REG_W-1:0]  dec_rs,
  input  logic [NSRC-1:0]        dec_rs_renb,
  input  logic [NSRC*XLEN-1:0]   dec_rdata,
  input  logic [REG_W-1:0]       dec_rd,
  input  logic                   dec_rd_wenb,
  input  logic                   dec_long,
  input  logic                   dec_issue,
  input  logic [REG_W-1:0]       exe_rd,
  input  logic                   exe_rd_wenb,
  input  logic [XLEN-1:0]        exe_result,
  input  logic                   exe_load,
  input  logic                   exe_csr,
  input  logic [REG_W-1:0]       mem_rd,
  input  logic                   mem_rd_wenb,
  input  logic [XLEN-1:0]        mem_result,
  input  logic [REG_W-1:0]       wrb_rd,
  input  logic                   wrb_rd_wenb,
  input  logic [XLEN-1:0]        wrb_result,
  input  logic                   lng_wenb,
  input  logic [REG_W-1:0]       lng_rd,
  input  logic [XLEN-1:0]        lng_result,
  output logic                   dec_stall,
  output logic                   dec_load_use,
  output logic                   dec_csr_use,
  output logic                   dec_lng_use,
  output logic [NSRC*XLEN-1:0]   dec_rs_data,
  output logic                   sb_full,
  output logic                   sb_err,
  output logic [CNT_W-1:0]       stall_count
);

  localparam int OW = $clog2(MAX_LONG + 1);

  logic [NREGS-1:0] pending;
  logic [OW-1:0]    outstanding;

  logic [NREGS-1:0] clr_mask, set_mask, pending_eff;
  logic             lng_clr_valid, sb_set, cnt_inc;
  logic             waw_stall, cap_stall;

  fwd_src_t         src       [NSRC];
  logic [NSRC-1:0]  exe_stall_v, lng_stall_v, load_use_v, csr_use_v;

  assign clr_mask      = lng_wenb ? reg_onehot(lng_rd) : '0;
  assign pending_eff   = pending & ~clr_mask;
  assign lng_clr_valid = lng_wenb && pending[lng_rd];
  assign sb_set        = dec_issue && dec_long && dec_rd_wenb && (dec_rd != '0);
  assign set_mask      = sb_set ? reg_onehot(dec_rd) : '0;
  // A set onto a register that stays pending would double count; only new entries add.
  assign cnt_inc       = sb_set && !pending_eff[dec_rd];
  assign sb_full       = (outstanding == OW'(MAX_LONG));

  for (genvar i = 0; i < NSRC; i++) begin : g_op
    operand_bypass #(.XLEN(XLEN)) u_bypass (
      .rs            (dec_rs[REG_W*i +: REG_W]),
      .renb          (dec_rs_renb[i]),
      .rdata         (dec_rdata[XLEN*i +: XLEN]),
      .exe_rd        (exe_rd),
      .exe_rd_wenb   (exe_rd_wenb),
      .exe_result    (exe_result),
      .exe_load      (exe_load),
      .exe_csr       (exe_csr),
      .mem_rd        (mem_rd),
      .mem_rd_wenb   (mem_rd_wenb),
      .mem_result    (mem_result),
      .wrb_rd        (wrb_rd),
      .wrb_rd_wenb   (wrb_rd_wenb),
      .wrb_result    (wrb_result),
      .lng_wenb      (lng_wenb),
      .lng_rd        (lng_rd),
      .lng_result    (lng_result),
      .pending_eff   (pending_eff),
      .src           (src[i]),
      .data          (dec_rs_data[XLEN*i +: XLEN]),
      .raw_exe_stall (exe_stall_v[i]),
      .raw_lng_stall (lng_stall_v[i])
    );
    assign load_use_v[i] = (src[i] == SRC_EXE) && exe_load;
    assign csr_use_v[i]  = (src[i] == SRC_EXE) && exe_csr;
  end

  // Stall causes are ORed across operands; a completion this cycle frees a slot for a new long op.
  always_comb begin
    waw_stall    = dec_rd_wenb && (dec_rd != '0) && pending_eff[dec_rd];
    cap_stall    = dec_long && sb_full && !lng_clr_valid;
    dec_load_use = |load_use_v;
    dec_csr_use  = |csr_use_v;
    dec_lng_use  = |lng_stall_v;
    dec_stall    = (|exe_stall_v) || dec_lng_use || waw_stall || cap_stall;
  end

  // Scoreboard bits and outstanding count; set wins over clear on the same register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending     <= '0;
      outstanding <= '0;
    end else begin
      pending     <= pending_eff | set_mask;
      outstanding <= outstanding + OW'(cnt_inc) - OW'(lng_clr_valid);
    end
  end

  // Sticky flag for a completion that matches no pending write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      sb_err <= 1'b0;
    else if (lng_wenb && !pending[lng_rd])
      sb_err <= 1'b1;
  end

  // Saturating stall-cycle counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      stall_count <= '0;
    else if (dec_stall && (stall_count != '1))
      stall_count <= stall_count + 1'b1;
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard with default parameters.
module tb_hazard_scoreboard;

  localparam int XLEN     = 32;
  localparam int NSRC     = 2;
  localparam int MAX_LONG = 4;
  localparam int CNT_W    = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic [NSRC*5-1:0] dec_rs;
  logic [NSRC-1:0]   dec_rs_renb;
  logic [NSRC*XLEN-1:0] dec_rdata;
  logic [4:0]        dec_rd;
  logic              dec_rd_wenb, dec_long, dec_issue;
  logic [4:0]        exe_rd, mem_rd, wrb_rd, lng_rd;
  logic              exe_rd_wenb, exe_load, exe_csr, mem_rd_wenb, wrb_rd_wenb, lng_wenb;
  logic [XLEN-1:0]   exe_result, mem_result, wrb_result, lng_result;
  logic              dec_stall, dec_load_use, dec_csr_use, dec_lng_use;
  logic [NSRC*XLEN-1:0] dec_rs_data;
  logic              sb_full, sb_err;
  logic [CNT_W-1:0]  stall_count;

  int errors = 0;
  int checks = 0;

  hazard_scoreboard #(.XLEN(XLEN), .NSRC(NSRC), .MAX_LONG(MAX_LONG), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .dec_rs(dec_rs), .dec_rs_renb(dec_rs_renb), .dec_rdata(dec_rdata),
    .dec_rd(dec_rd), .dec_rd_wenb(dec_rd_wenb), .dec_long(dec_long), .dec_issue(dec_issue),
    .exe_rd(exe_rd), .exe_rd_wenb(exe_rd_wenb), .exe_result(exe_result),
    .exe_load(exe_load), .exe_csr(exe_csr),
    .mem_rd(mem_rd), .mem_rd_wenb(mem_rd_wenb), .mem_result(mem_result),
    .wrb_rd(wrb_rd), .wrb_rd_wenb(wrb_rd_wenb), .wrb_result(wrb_result),
    .lng_wenb(lng_wenb), .lng_rd(lng_rd), .lng_result(lng_result),
    .dec_stall(dec_stall), .dec_load_use(dec_load_use), .dec_csr_use(dec_csr_use),
    .dec_lng_use(dec_lng_use), .dec_rs_data(dec_rs_data),
    .sb_full(sb_full), .sb_err(sb_err), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    dec_rs = '0; dec_rs_renb = '0; dec_rdata = '0;
    dec_rd = '0; dec_rd_wenb = 1'b0; dec_long = 1'b0; dec_issue = 1'b0;
    exe_rd = '0; exe_rd_wenb = 1'b0; exe_result = '0; exe_load = 1'b0; exe_csr = 1'b0;
    mem_rd = '0; mem_rd_wenb = 1'b0; mem_result = '0;
    wrb_rd = '0; wrb_rd_wenb = 1'b0; wrb_result = '0;
    lng_wenb = 1'b0; lng_rd = '0; lng_result = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_long(input logic [4:0] rd);
    idle();
    dec_rd = rd; dec_rd_wenb = 1'b1; dec_long = 1'b1; dec_issue = 1'b1;
    step();
  endtask

  initial begin
    idle();
    reset = 1'b1;
    #1;
    chk("rst_stall",  32'(dec_stall), 32'd0);
    chk("rst_full",   32'(sb_full), 32'd0);
    chk("rst_err",    32'(sb_err), 32'd0);
    chk("rst_count",  32'(stall_count), 32'd0);
    step();
    reset = 1'b0;
    step();

    // Forwarding priority on operand 0
    dec_rs = {5'd0, 5'd5}; dec_rs_renb = 2'b01; dec_rdata = {32'h0, 32'h99};
    exe_rd = 5'd5; exe_rd_wenb = 1'b1; exe_result = 32'h11;
    mem_rd = 5'd5; mem_rd_wenb = 1'b1; mem_result = 32'h22;
    wrb_rd = 5'd5; wrb_rd_wenb = 1'b1; wrb_result = 32'h33;
    #1;
    chk("fwd_exe",       dec_rs_data[31:0], 32'h11);
    chk("fwd_exe_stall", 32'(dec_stall), 32'd0);
    exe_rd_wenb = 1'b0; #1;
    chk("fwd_mem", dec_rs_data[31:0], 32'h22);
    mem_rd = 5'd6; #1;
    chk("fwd_wrb", dec_rs_data[31:0], 32'h33);
    wrb_rd_wenb = 1'b0; #1;
    chk("fwd_rf", dec_rs_data[31:0], 32'h99);
    step();

    // Load-use on operand 1, then the load forwarded from MEM
    idle();
    dec_rs = {5'd7, 5'd0}; dec_rs_renb = 2'b10;
    exe_rd = 5'd7; exe_rd_wenb = 1'b1; exe_load = 1'b1; exe_result = 32'h5A;
    mem_rd = 5'd7; mem_rd_wenb = 1'b1; mem_result = 32'h77;
    #1;
    chk("ld_stall", 32'(dec_stall), 32'd1);
    chk("ld_use",   32'(dec_load_use), 32'd1);
    chk("ld_csr",   32'(dec_csr_use), 32'd0);
    step();
    chk("ld_count", 32'(stall_count), 32'd1);
    idle();
    dec_rs = {5'd7, 5'd0}; dec_rs_renb = 2'b10;
    mem_rd = 5'd7; mem_rd_wenb = 1'b1; mem_result = 32'hAB;
    #1;
    chk("ld_mem_data",  dec_rs_data[63:32], 32'hAB);
    chk("ld_mem_stall", 32'(dec_stall), 32'd0);
    exe_rd = 5'd7; exe_rd_wenb = 1'b1; exe_csr = 1'b1; #1;
    chk("csr_use",   32'(dec_csr_use), 32'd1);
    chk("csr_stall", 32'(dec_stall), 32'd1);
    step();
    chk("csr_count", 32'(stall_count), 32'd2);

    // Long op to x9: RAW, WAW, then completion forwarding
    issue_long(5'd9);
    idle();
    dec_rs = {5'd0, 5'd9}; dec_rs_renb = 2'b01; #1;
    chk("raw_stall", 32'(dec_stall), 32'd1);
    chk("raw_lng",   32'(dec_lng_use), 32'd1);
    dec_rs_renb = 2'b00; dec_rd = 5'd9; dec_rd_wenb = 1'b1; #1;
    chk("waw_stall", 32'(dec_stall), 32'd1);
    chk("waw_lng",   32'(dec_lng_use), 32'd0);
    idle();
    dec_rs = {5'd0, 5'd9}; dec_rs_renb = 2'b01;
    lng_wenb = 1'b1; lng_rd = 5'd9; lng_result = 32'hCAFE; #1;
    chk("lng_fwd",   dec_rs_data[31:0], 32'hCAFE);
    chk("lng_stall", 32'(dec_stall), 32'd0);
    chk("lng_use0",  32'(dec_lng_use), 32'd0);
    step();
    idle();
    dec_rs = {5'd0, 5'd9}; dec_rs_renb = 2'b01; dec_rdata = {32'h0, 32'h55}; #1;
    chk("post_rf",    dec_rs_data[31:0], 32'h55);
    chk("post_stall", 32'(dec_stall), 32'd0);
    chk("post_pend9", 32'(dut.pending[9]), 32'd0);

    // Fill the scoreboard, then issue alongside a completion
    issue_long(5'd10);
    issue_long(5'd11);
    issue_long(5'd12);
    chk("not_full3", 32'(sb_full), 32'd0);
    issue_long(5'd13);
    chk("full", 32'(sb_full), 32'd1);
    idle();
    dec_rd = 5'd14; dec_rd_wenb = 1'b1; dec_long = 1'b1; #1;
    chk("cap_stall", 32'(dec_stall), 32'd1);
    lng_wenb = 1'b1; lng_rd = 5'd10; #1;
    chk("cap_free", 32'(dec_stall), 32'd0);
    dec_issue = 1'b1;
    step();
    chk("full_kept",   32'(sb_full), 32'd1);
    chk("outst_4",     32'(dut.outstanding), 32'd4);
    chk("pend14",      32'(dut.pending[14]), 32'd1);
    chk("pend10",      32'(dut.pending[10]), 32'd0);

    // Same-cycle completion and reissue on x3, then a stray completion to x4
    idle(); lng_wenb = 1'b1; lng_rd = 5'd11; step();
    idle(); lng_wenb = 1'b1; lng_rd = 5'd12; step();
    chk("outst_2", 32'(dut.outstanding), 32'd2);
    issue_long(5'd3);
    idle();
    dec_rd = 5'd3; dec_rd_wenb = 1'b1; dec_long = 1'b1;
    lng_wenb = 1'b1; lng_rd = 5'd3; #1;
    chk("reissue_nostall", 32'(dec_stall), 32'd0);
    dec_issue = 1'b1;
    step();
    chk("pend3",    32'(dut.pending[3]), 32'd1);
    chk("outst_3a", 32'(dut.outstanding), 32'd3);
    chk("err_clr",  32'(sb_err), 32'd0);
    idle(); lng_wenb = 1'b1; lng_rd = 5'd4; step();
    chk("err_set",  32'(sb_err), 32'd1);
    chk("outst_3b", 32'(dut.outstanding), 32'd3);

    // x0 never hazards
    idle();
    dec_rs = {5'd0, 5'd0}; dec_rs_renb = 2'b01; dec_rdata = {32'h0, 32'h77};
    exe_rd = 5'd0; exe_rd_wenb = 1'b1; exe_load = 1'b1; exe_result = 32'h1; #1;
    chk("x0_data",  dec_rs_data[31:0], 32'h77);
    chk("x0_stall", 32'(dec_stall), 32'd0);

    // Asynchronous reset mid-operation with 3 outstanding
    idle();
    dec_rs = {5'd0, 5'd13}; dec_rs_renb = 2'b01; #1;
    chk("pre_rst_lng", 32'(dec_lng_use), 32'd1);
    reset = 1'b1; #1;
    chk("arst_lng",   32'(dec_lng_use), 32'd0);
    chk("arst_err",   32'(sb_err), 32'd0);
    chk("arst_count", 32'(stall_count), 32'd0);
    chk("arst_pend",  dut.pending, 32'd0);
    chk("arst_outst", 32'(dut.outstanding), 32'd0);
    exe_rd = 5'd13; exe_rd_wenb = 1'b1; exe_load = 1'b1; #1;
    chk("arst_ld_stall", 32'(dec_stall), 32'd1);
    chk("arst_ld_use",   32'(dec_load_use), 32'd1);
    step();
    chk("arst_hold_count", 32'(stall_count), 32'd0);
    reset = 1'b0;

    // Saturation of the stall counter under a continuous load-use stall
    for (int i = 0; i < 3; i++) step();
    chk("sat_count3", 32'(stall_count), 32'd3);
    for (int i = 3; i < (1 << CNT_W) + 5; i++) step();
    chk("sat_count", 32'(stall_count), 32'hFFFF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Parametrised successor to the DEC-stage bypass/stall unit of the RISC-V core. It forwards EXE/MEM/WRB results and a long-latency completion port to NSRC source operands. It also keeps a per-register scoreboard of in-flight long-latency writes (divider, variable-latency loads) and raises DEC stalls on RAW/WAW hazards against them. It sits beside the DEC stage, between the register file read ports and the DEC/EXE pipeline register.

## Interface
- XLEN, 32, datapath width
- NSRC, 2, number of DEC source operands (2 or 3)
- MAX_LONG, 4, maximum outstanding long-latency writes (1..31)
- CNT_W, 16, stall-cycle counter width
- clk  in  1  core clock, all state on rising edge
- reset  in  1  asynchronous, active-high
- dec_rs  in  NSRC*5  source register addresses, operand i at [5i+4:5i]
- dec_rs_renb  in  NSRC  1 => operand i used
- dec_rdata  in  NSRC*XLEN  register-file read data
- dec_rd, dec_rd_wenb  in  5, 1  DEC destination and write enable
- dec_long  in  1  DEC instruction writes rd via the long-latency port
- dec_issue  in  1  DEC instruction advances to EXE this cycle (already gated by dec_stall)
- exe_rd, exe_rd_wenb, exe_result, exe_load, exe_csr  in  5, 1, XLEN, 1, 1  EXE-stage info
- mem_rd, mem_rd_wenb, mem_result  in  5, 1, XLEN  MEM-stage info
- wrb_rd, wrb_rd_wenb, wrb_result  in  5, 1, XLEN  WRB-stage info
- lng_wenb, lng_rd, lng_result  in  1, 5, XLEN  long-unit completion, written to the register file at this edge
- dec_stall  out  1  stall DEC
- dec_load_use, dec_csr_use, dec_lng_use  out  1 each  stall cause flags
- dec_rs_data  out  NSRC*XLEN  forwarded operands
- sb_full  out  1  outstanding == MAX_LONG
- sb_err  out  1  sticky: completion to a non-pending register
- stall_count  out  CNT_W  saturating count of stalled cycles

## Operation
- x0 never hazards: rs==0 gets dec_rdata, and rd==0 is never scoreboarded.
- Per-operand forwarding priority when renb=1: EXE > MEM > WRB > LNG completion > register file. Matching needs equal address and the stage wenb.
- An EXE match with exe_load or exe_csr stalls the cycle and sets dec_load_use or dec_csr_use. There is no fallthrough to older stages.
- Long ops travel EXE/MEM/WRB with rd_wenb=0. Their writes are seen only via the scoreboard and the lng_* port.
- pending_eff = pending & ~(lng_wenb ? onehot(lng_rd) : 0).
- RAW stall: an operand is used, its register is pending_eff, and it has no EXE/MEM/WRB match. This sets dec_lng_use.
- WAW stall: dec_rd_wenb, dec_rd!=0, and pending_eff[dec_rd].
- Capacity stall: dec_long and sb_full, unless lng_wenb clears an entry this cycle.
- dec_stall is the OR of all stall conditions across operands. dec_rs_data is still driven when stalled, but it is don't-care.
- Scoreboard update at clk:
  - lng_wenb clears pending[lng_rd].
  - dec_issue & dec_long & dec_rd_wenb & dec_rd!=0 sets pending[dec_rd]; set wins over clear on the same register.
  - outstanding changes by +set -clear, with a net 0 when both occur.
- Completion to a non-pending register: no count change, and sb_err is set until reset.
- stall_count increments on every cycle with dec_stall=1 and saturates at all-ones.

## Timing
- Forwarding and stall outputs are combinational from inputs plus registered state, within the same cycle.
- Scoreboard, outstanding, sb_err and stall_count update one cycle after the enabling inputs.
- A long op issued in cycle t makes its rd pending from t+1.
- A completion in cycle c forwards lng_result in cycle c. From c+1 the register-file value is used.
- Reset (asynchronous, any cycle, including mid-operation):
  - pending=0, outstanding=0, sb_full=0, sb_err=0, stall_count=0, dec_lng_use=0.
  - dec_stall, dec_load_use, dec_csr_use and dec_rs_data follow the EXE/MEM/WRB inputs only.
  - In-flight long ops are forgotten; the core flushes the long unit on reset.

## Structure
- Package hazard_pkg holds: REG_W=5, NREGS=32, and the enum fwd_src_t {SRC_RF, SRC_EXE, SRC_MEM, SRC_WRB, SRC_LNG}.
- Sub-module operand_bypass (combinational): one address/renb/rdata in, producing fwd_src_t, data, and raw_exe_stall / raw_lng_stall. It is instantiated NSRC times by generate.
- The top level holds the scoreboard register, outstanding counter, sticky error and stall counter.

## Test plan
- rs1=5 with exe_rd=5, exe_wenb=1, exe_result=0x11; mem_rd=5, mem_result=0x22 -> dec_rs_data[0]=0x11, dec_stall=0.
- rs2=7 with exe_rd=7 and exe_load=1 -> dec_stall=1, dec_load_use=1. The next cycle, with the load in MEM and mem_result=0xAB -> data=0xAB, no stall.
- Issue a long op to rd=9, then rs1=9 -> stall with dec_lng_use=1. lng_wenb to rd=9 with 0xCAFE -> forwarded the same cycle, stall drops, and pending[9]=0 the next cycle.
- Issue MAX_LONG long ops to distinct rd -> sb_full=1 and the next dec_long stalls. A concurrent completion lets it issue, and outstanding stays MAX_LONG.
- Completion and issue to rd=3 in the same cycle -> pending[3]=1 afterwards. A completion to non-pending rd=4 -> sb_err=1, outstanding unchanged.
- rs1=0 with exe_rd=0 and exe_wenb=1; assert reset with 3 ops outstanding -> no stall, and all state clears immediately. Drive 2^CNT_W+5 stall cycles -> stall_count saturates at all-ones.
